// File: rtl/arb_pkg.sv
// Shared definitions for unified_mem_arbiter.
// Contents:
//   resp_state_t - response FSM encoding (IDLE, RESP_IF, RESP_D_RD, RESP_D_WR)
//   *_DEF        - default widths and starvation bound used by the top level
//   sat_inc      - saturating increment helper for 16-bit counters
// Optional feature macro: ARB_PERF_CNT_EN (used by the top level).
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RESP_IF   = 2'd1,
      RESP_D_RD = 2'd2,
      RESP_D_WR = 2'd3
   } resp_state_t;

   localparam int unsigned ADDR_W_DEF       = 8;
   localparam int unsigned DATA_W_DEF       = 32;
   localparam int unsigned MAX_D_STREAK_DEF = 3;
   localparam int unsigned CNT_W_DEF        = 16;

   // Adds one unless already at all-ones.
   function automatic logic [CNT_W_DEF-1:0] sat_inc(input logic [CNT_W_DEF-1:0] val);
      logic [CNT_W_DEF-1:0] res;
      if (val == {CNT_W_DEF{1'b1}}) begin
         res = val;
      end else begin
         res = val + {{(CNT_W_DEF-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Core-side bus of the unified memory arbiter: fetch (IF) and load/store (D)
// request/response channels plus the fetch stall indication.
// Modports:
//   master - the pipeline: drives requests, receives grants/responses
//   slave  - the arbiter: receives requests, drives grants/responses
interface unified_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) ();
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_valid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_be;
   logic              d_gnt;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;
   logic              stall_if;

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
      input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, stall_if
   );

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
      output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, stall_if
   );
endinterface

// File: rtl/arb_streak_ctr.sv
// Saturating starvation counter: counts consecutive data grants taken while a
// fetch is waiting.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   inc        - a data grant happened while the fetch was pending
//   clr        - fetch granted or fetch not requesting
//   at_max     - counter equals MAX, fetch must win next conflict
module arb_streak_ctr #(
   parameter int unsigned MAX = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max
);
   localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

   logic [W-1:0] streak_r;

   // Streak register: clear has precedence, increment stops at MAX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak_r <= {W{1'b0}};
      end else if (clr) begin
         streak_r <= {W{1'b0}};
      end else if (inc && !at_max) begin
         streak_r <= streak_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         streak_r <= streak_r;
      end
   end

   assign at_max = (streak_r == W'(MAX));
endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported synchronous-read memory between the fetch
// stage (IF) and the load/store stage (D). One grant per cycle, response one
// cycle after the grant. Data wins conflicts unless it has already won
// MAX_D_STREAK times in a row against a waiting fetch.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   core (slave)  - IF/D request, grant and response channels, stall_if
//   mem_*         - memory strobe, write, address, data, byte enables, rdata
//   perf_conflict, perf_if_stall - saturating counters, only when the
//                   ARB_PERF_CNT_EN macro is defined
module unified_mem_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned MAX_D_STREAK = MAX_D_STREAK_DEF,
   parameter int unsigned CNT_W        = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   unified_mem_arbiter_if.slave core,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [3:0]           mem_be,
   input  logic [DATA_W-1:0]    mem_rdata
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]     perf_conflict,
   output logic [CNT_W-1:0]     perf_if_stall
`endif
);
   resp_state_t state_r;
   logic        if_gnt_s;
   logic        d_gnt_s;
   logic        at_max_s;

   arb_streak_ctr #(.MAX(MAX_D_STREAK)) u_streak (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (d_gnt_s & core.if_req),
      .clr    (if_gnt_s | ~core.if_req),
      .at_max (at_max_s)
   );

   // Grant selection; grants are held off while reset is asserted.
   always_comb begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
      if (rst_n) begin
         if (core.d_req && !(core.if_req && at_max_s)) begin
            d_gnt_s = 1'b1;
         end else begin
            if_gnt_s = core.if_req;
         end
      end else begin
         if_gnt_s = 1'b0;
         d_gnt_s  = 1'b0;
      end
   end

   // Memory port mux: winner's fields, fetches are always full-word reads.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_be    = 4'h0;
      if (d_gnt_s) begin
         mem_en    = 1'b1;
         mem_we    = core.d_we;
         mem_addr  = core.d_addr;
         mem_wdata = core.d_wdata;
         mem_be    = core.d_be;
      end else if (if_gnt_s) begin
         mem_en    = 1'b1;
         mem_we    = 1'b0;
         mem_addr  = core.if_addr;
         mem_wdata = {DATA_W{1'b0}};
         mem_be    = 4'hF;
      end else begin
         mem_en = 1'b0;
      end
   end

   // Response FSM: remembers which requester owns next cycle's memory result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else if (if_gnt_s) begin
         state_r <= RESP_IF;
      end else if (d_gnt_s && core.d_we) begin
         state_r <= RESP_D_WR;
      end else if (d_gnt_s) begin
         state_r <= RESP_D_RD;
      end else begin
         state_r <= IDLE;
      end
   end

   // Response decode; rdata of the side not being answered stays zero.
   always_comb begin
      core.if_valid = 1'b0;
      core.if_rdata = {DATA_W{1'b0}};
      core.d_valid  = 1'b0;
      core.d_rdata  = {DATA_W{1'b0}};
      case (state_r)
         RESP_IF: begin
            core.if_valid = 1'b1;
            core.if_rdata = mem_rdata;
         end
         RESP_D_RD: begin
            core.d_valid = 1'b1;
            core.d_rdata = mem_rdata;
         end
         RESP_D_WR: begin
            core.d_valid = 1'b1;
         end
         default: begin
            core.if_valid = 1'b0;
            core.d_valid  = 1'b0;
         end
      endcase
   end

   assign core.if_gnt   = if_gnt_s;
   assign core.d_gnt    = d_gnt_s;
   assign core.stall_if = core.if_req & ~if_gnt_s;

`ifdef ARB_PERF_CNT_EN
   // Saturating conflict and fetch-stall cycle counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_conflict <= {CNT_W{1'b0}};
         perf_if_stall <= {CNT_W{1'b0}};
      end else begin
         if (core.if_req && core.d_req && (perf_conflict != {CNT_W{1'b1}})) begin
            perf_conflict <= perf_conflict + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            perf_conflict <= perf_conflict;
         end
         if (core.if_req && !if_gnt_s && (perf_if_stall != {CNT_W{1'b1}})) begin
            perf_if_stall <= perf_if_stall + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            perf_if_stall <= perf_if_stall;
         end
      end
   end
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter with a behavioural synchronous
// memory. Expected responses are queued at grant time and matched when the
// corresponding valid appears. Define ARB_PERF_CNT_EN to exercise the counters.
module tb_unified_mem_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = 32'd0;
`ifdef ARB_PERF_CNT_EN
   logic [15:0] perf_conflict;
   logic [15:0] perf_if_stall;
`endif

   int checks   = 0;
   int failures = 0;
   logic [31:0] if_q[$];
   logic [31:0] d_q[$];
   logic [31:0] mem_arr [0:63];

   always #5 clk = ~clk;

   unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) core ();

   unified_mem_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .core      (core),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_conflict (perf_conflict),
      .perf_if_stall (perf_if_stall)
`endif
   );

   // Behavioural single-port synchronous-read memory.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_be[b]) mem_arr[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end else begin
            mem_rdata <= mem_arr[mem_addr[7:2]];
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Scoreboard: every valid must match the oldest expected response.
   always @(negedge clk) begin
      if (core.if_valid === 1'b1) begin
         if (if_q.size() == 0) check_eq("if_valid_unexpected", 32'(if_q.size()), 32'd1);
         else check_eq("if_rdata", core.if_rdata, if_q.pop_front());
      end
      if (core.d_valid === 1'b1) begin
         if (d_q.size() == 0) check_eq("d_valid_unexpected", 32'(d_q.size()), 32'd1);
         else check_eq("d_rdata", core.d_rdata, d_q.pop_front());
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      core.if_req  = 1'b0;
      core.if_addr = 8'h00;
      core.d_req   = 1'b0;
      core.d_we    = 1'b0;
      core.d_addr  = 8'h00;
      core.d_wdata = 32'h0;
      core.d_be    = 4'h0;
   endtask

   task automatic both_req();
      core.if_req  = 1'b1;
      core.if_addr = 8'h0C;
      core.d_req   = 1'b1;
      core.d_we    = 1'b0;
      core.d_addr  = 8'h10;
      core.d_be    = 4'hF;
   endtask

   logic [31:0] if_exp [0:2];
   logic        exp_d;

   initial begin
      for (int i = 0; i < 64; i++) mem_arr[i] = 32'h0;
      mem_arr[0] = 32'h00000083;
      mem_arr[1] = 32'h00100103;
      mem_arr[2] = 32'h008001EF;
      mem_arr[3] = 32'h00C00093;
      mem_arr[4] = 32'hCAFE0010;
      if_exp[0] = 32'h00000083;
      if_exp[1] = 32'h00100103;
      if_exp[2] = 32'h008001EF;

      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_if_gnt", 32'(core.if_gnt), 32'd0);
      check_eq("rst_d_gnt", 32'(core.d_gnt), 32'd0);
      check_eq("rst_if_valid", 32'(core.if_valid), 32'd0);
      check_eq("rst_d_valid", 32'(core.d_valid), 32'd0);
      check_eq("rst_mem_en", 32'(mem_en), 32'd0);
      core.if_req  = 1'b1;
      core.if_addr = 8'h04;
      #1;
      check_eq("rst_gnt_held", 32'(core.if_gnt), 32'd0);

      // Grant at 0x04, then reset in the response cycle.
      next_cycle();
      rst_n = 1'b1;
      #1;
      check_eq("rel_if_gnt", 32'(core.if_gnt), 32'd1);
      check_eq("rel_mem_addr", 32'(mem_addr), 32'h04);
      next_cycle();
      rst_n = 1'b0;
      core.if_addr = 8'h08;
      #1;
      check_eq("mid_rst_if_valid", 32'(core.if_valid), 32'd0);
      check_eq("mid_rst_if_rdata", core.if_rdata, 32'd0);
      check_eq("mid_rst_mem_en", 32'(mem_en), 32'd0);
      check_eq("mid_rst_stall_gnt", 32'(core.if_gnt), 32'd0);
      next_cycle();
      check_eq("mid_rst_if_valid2", 32'(core.if_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_if_gnt", 32'(core.if_gnt), 32'd1);
      if_q.push_back(32'h008001EF);

      // Fetch-only stream.
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         core.if_addr = 8'(4 * i);
         #1;
         check_eq("ifonly_gnt", 32'(core.if_gnt), 32'd1);
         if_q.push_back(if_exp[i]);
      end

      // Load vs fetch conflict.
      next_cycle();
      both_req();
      #1;
      check_eq("conf_d_gnt", 32'(core.d_gnt), 32'd1);
      check_eq("conf_if_gnt", 32'(core.if_gnt), 32'd0);
      check_eq("conf_stall_if", 32'(core.stall_if), 32'd1);
      check_eq("conf_mem_addr", 32'(mem_addr), 32'h10);
      d_q.push_back(32'hCAFE0010);
      next_cycle();
      core.d_req = 1'b0;
      #1;
      check_eq("conf_if_gnt2", 32'(core.if_gnt), 32'd1);
      check_eq("conf_mem_be", 32'(mem_be), 32'hF);
      if_q.push_back(32'h00C00093);

      // Starvation bound: D,D,D,IF repeating.
      next_cycle();
      both_req();
      for (int k = 0; k < 8; k++) begin
         if (k > 0) next_cycle();
         #1;
         exp_d = ((k % 4) != 3);
         check_eq("starve_d_gnt", 32'(core.d_gnt), 32'(exp_d));
         check_eq("starve_if_gnt", 32'(core.if_gnt), 32'(!exp_d));
         if (exp_d) d_q.push_back(32'hCAFE0010);
         else if_q.push_back(32'h00C00093);
      end

      // Store then load back.
      next_cycle();
      idle_inputs();
      core.d_req   = 1'b1;
      core.d_we    = 1'b1;
      core.d_addr  = 8'h0C;
      core.d_wdata = 32'h0000000A;
      core.d_be    = 4'hF;
      #1;
      check_eq("st_d_gnt", 32'(core.d_gnt), 32'd1);
      check_eq("st_mem_we", 32'(mem_we), 32'd1);
      check_eq("st_mem_wdata", mem_wdata, 32'h0000000A);
      d_q.push_back(32'h0);
      next_cycle();
      core.d_we = 1'b0;
      #1;
      check_eq("ld_d_gnt", 32'(core.d_gnt), 32'd1);
      check_eq("ld_mem_we", 32'(mem_we), 32'd0);
      d_q.push_back(32'h0000000A);
      next_cycle();
      idle_inputs();
      #1;
      check_eq("idle_mem_en", 32'(mem_en), 32'd0);
      check_eq("idle_mem_addr", 32'(mem_addr), 32'd0);
      check_eq("idle_mem_be", 32'(mem_be), 32'd0);
      next_cycle();

`ifdef ARB_PERF_CNT_EN
      rst_n = 1'b0;
      #1;
      check_eq("perf_rst_conflict", 32'(perf_conflict), 32'd0);
      check_eq("perf_rst_stall", 32'(perf_if_stall), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      both_req();
      // 3 conflicts (all stall), 1 data-only cycle clearing the streak, 2 conflicts.
      for (int k = 0; k < 6; k++) begin
         if (k > 0) next_cycle();
         core.if_req = (k != 3);
         #1;
         check_eq("perf_d_gnt", 32'(core.d_gnt), 32'd1);
         d_q.push_back(32'hCAFE0010);
      end
      next_cycle();
      idle_inputs();
      #1;
      check_eq("perf_conflict", 32'(perf_conflict), 32'd5);
      check_eq("perf_if_stall", 32'(perf_if_stall), 32'd5);
`endif

      repeat (3) next_cycle();
      check_eq("if_q_drained", 32'(if_q.size()), 32'd0);
      check_eq("d_q_drained", 32'(d_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, synchronous-read unified instruction/data memory between the fetch stage (IF) and the load/store stage (D).
- Grants at most one access per cycle. Read data and write acks return exactly one cycle after the grant.
- Data has priority. A streak counter bounds fetch starvation.
- Sits between the core pipeline and the memory array that replaces the separate instruction and data memories.

Parameters:
- ADDR_W, 8, byte address width (64 words x 4 bytes)
- DATA_W, 32, data width
- MAX_D_STREAK, 3, max consecutive D grants while IF is pending before IF is forced
- CNT_W, 16, width of performance counters (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch byte address; word-aligned
- if_gnt  out  1  fetch accepted this cycle
- if_valid  out  1  fetch data valid; one cycle after if_gnt
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_be  in  4  byte enables for stores
- d_gnt  out  1  data accepted this cycle
- d_valid  out  1  load data or store ack; one cycle after d_gnt
- d_rdata  out  DATA_W  load data; 0 on store ack
- stall_if  out  1  if_req high and not granted this cycle
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0

Behaviour:
- Handshake:
  - Transfer occurs when req and gnt are high in the same cycle.
  - gnt is combinational from the req inputs and arbiter state.
  - Requester must hold addr, data and we stable until gnt.
- Arbitration:
  - Only d_req: D wins.
  - Only if_req: IF wins.
  - Both: D wins unless streak == MAX_D_STREAK, in which case IF wins.
- Streak counter:
  - Increments on each D grant while if_req is high.
  - Clears on any IF grant, or on any cycle with if_req low.
  - Saturates at MAX_D_STREAK.
- Memory drive:
  - Winner's fields drive mem_* in the grant cycle; mem_en = if_gnt | d_gnt.
  - IF grants force mem_we=0 and mem_be=4'hF.
  - With no grant: mem_en=0 and all other mem_* outputs are 0.
- Response FSM (registered): states IDLE, RESP_IF, RESP_D_RD, RESP_D_WR.
  - Next state is set by this cycle's grant: IF grant -> RESP_IF; D load -> RESP_D_RD; D store -> RESP_D_WR; no grant -> IDLE.
  - RESP_IF: if_valid=1, if_rdata=mem_rdata.
  - RESP_D_RD: d_valid=1, d_rdata=mem_rdata.
  - RESP_D_WR: d_valid=1, d_rdata=0.
  - A new grant may issue in any response cycle, giving one access per cycle throughput.
- Unused rdata outputs are driven to 0.
- stall_if = if_req & ~if_gnt.
- Reset:
  - Asynchronous assertion: state=IDLE, streak=0, all valid and gnt outputs 0, mem_en=0.
  - An outstanding response is dropped and never presented.
  - First grant is possible in the first cycle after deassertion.
- Misaligned if_addr (bits [1:0] != 0) is passed through unchanged. Alignment is the requester's responsibility.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- When defined, adds output ports:
  - perf_conflict [CNT_W]: counts cycles with if_req & d_req.
  - perf_if_stall [CNT_W]: counts cycles with stall_if.
  - Both reset to 0 and saturate at all-ones.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package (arb_pkg) holds:
  - Response-state enum/localparams IDLE=2'd0, RESP_IF=2'd1, RESP_D_RD=2'd2, RESP_D_WR=2'd3.
  - Default widths.
- One natural sub-module: arb_streak_ctr, the saturating starvation counter with inc, clr and at_max.

Test Plan:
- Reset mid-response:
  - Stimulus: IF granted at 0x04, rst_n pulsed low next cycle.
  - Response: if_valid stays 0, all outputs 0; after release, if_req at 0x08 is granted in the first cycle.
- IF only:
  - Stimulus: if_req held with addresses 0x00, 0x04, 0x08 on consecutive cycles; memory preloaded 0x00000083, 0x00100103, 0x008001EF.
  - Response: if_gnt every cycle; if_valid with those values one cycle after each grant.
- Load vs. fetch conflict:
  - Stimulus: d_req load at 0x10 and if_req at 0x0C in the same cycle.
  - Response: d_gnt=1, if_gnt=0, stall_if=1; next cycle d_valid with mem[0x10] and IF granted.
- Starvation bound:
  - Stimulus: d_req and if_req held continuously, MAX_D_STREAK=3.
  - Response: grant pattern D,D,D,IF,D,D,D,IF.
- Store ack:
  - Stimulus: d_we=1, d_addr=0x0C, d_wdata=0x0000000A, d_be=4'hF.
  - Response: mem_we=1 in the grant cycle; next cycle d_valid=1, d_rdata=0; a following load of 0x0C returns 0x0000000A.
- ARB_PERF_CNT_EN build:
  - Stimulus: 5 conflict cycles, 5 stall cycles.
  - Response: perf_conflict=5, perf_if_stall=5.
